// File: rtl/pusch_top.sv
// Simplified NR PUSCH transmit chain: serial TB capture, CRC16 attach, circular rate matching,
// Gold scrambling and QPSK/16QAM mapping to signed I/Q samples.
// Latency: one symbol per clk/16 tick, registered 1 clk after the tick; 1600-clk Gold warm-up per TB.
// Backpressure: none; the downstream must accept a symbol on every tick while Data_valid is high.
//
// Ports:
//   clk, reset (async, clears everything), reset_fft (async, output regs only),
//   reset_div (async, tick divider only)
//   enable / Data_in      : serial transport-block bits, sampled on tick
//   rv_number, available_coded_bits, modulation_order : rate-matching / modulation controls
//   N_Rapid, N_Rnti, N_cell_ID, Config : scrambler initialisation
//   base_graph, process_number, N_slot_frame .. Sym_End_REM : latched, no datapath effect
//   Data_r, Data_i, Data_valid : mapped I/Q symbol and its qualifier
module pusch_top #(
   parameter int WIDTH_IFFT = 26,
   parameter int MAX_TB     = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         reset_fft,
   input  logic                         reset_div,
   input  logic                         enable,
   input  logic                         Data_in,
   input  logic [1:0]                   base_graph,
   input  logic [1:0]                   rv_number,
   input  logic [3:0]                   process_number,
   input  logic [16:0]                  available_coded_bits,
   input  logic [2:0]                   modulation_order,
   input  logic [5:0]                   N_Rapid,
   input  logic [15:0]                  N_Rnti,
   input  logic [9:0]                   N_cell_ID,
   input  logic                         Config,
   input  logic [4:0]                   N_slot_frame,
   input  logic [6:0]                   N_rb,
   input  logic [1:0]                   En_hopping,
   input  logic [3:0]                   N_symbol,
   input  logic [10:0]                  N_sc_start,
   input  logic [3:0]                   Sym_Start_REM,
   input  logic [3:0]                   Sym_End_REM,
   output logic signed [WIDTH_IFFT-1:0] Data_r,
   output logic signed [WIDTH_IFFT-1:0] Data_i,
   output logic                         Data_valid
);

   localparam int BUF_W = MAX_TB + 16;
   localparam int IDX_W = $clog2(BUF_W + 1);
   localparam int RSV_W = 43;
   localparam int U_INT = 1 << (WIDTH_IFFT - 5);

   localparam logic signed [WIDTH_IFFT-1:0] AMP2 = WIDTH_IFFT'(2 * U_INT);
   localparam logic signed [WIDTH_IFFT-1:0] AMP4 = WIDTH_IFFT'(4 * U_INT);
   localparam logic signed [WIDTH_IFFT-1:0] AMP6 = WIDTH_IFFT'(6 * U_INT);
   localparam logic [10:0]      WARM_LAST = 11'd1599;
   localparam logic [IDX_W-1:0] MAX_CNT   = IDX_W'(MAX_TB);
   localparam logic [IDX_W-1:0] CRC_LEN   = IDX_W'(16);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CRC,
      ST_WARM,
      ST_STREAM
   } state_t;

   state_t state, state_nx;

   // ---------------- clk/16 tick ----------------
   logic [3:0] div_cnt;
   logic       div_rst;
   logic       tick;

   assign div_rst = reset | reset_div;

   always_ff @(posedge clk or posedge div_rst) begin
      if (div_rst) div_cnt <= '0;
      else         div_cnt <= div_cnt + 4'd1;
   end

   assign tick = (div_cnt == 4'hF);

   // ---------------- datapath state ----------------
   logic [BUF_W-1:0] tb_buf;
   logic [IDX_W-1:0] cap_cnt;
   logic [IDX_W-1:0] n_len;
   logic [IDX_W-1:0] pos;
   logic [15:0]      crc;
   logic [15:0]      crc_rev;
   logic [30:0]      x1, x2;
   logic [30:0]      x1_nx, x2_nx;
   logic [30:0]      c_init;
   logic [10:0]      warm_cnt;
   logic [16:0]      bits_left;
   logic [16:0]      qm_len;
   logic             qm4;
   logic [RSV_W-1:0] cfg_rsv;
   logic [IDX_W+1:0] rv_prod;
   logic [IDX_W-1:0] k0;
   logic [IDX_W-1:0] idx [0:4];
   logic [IDX_W-1:0] pos_nx;
   logic [3:0]       bits_sc;
   logic signed [WIDTH_IFFT-1:0] mag_i, mag_q, sym_i, sym_q;
   logic             emit, fin, e_short;

   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic d);
      logic fb;
      fb = c[15] ^ d;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   // Gold LFSRs hold 31 consecutive sequence values; bit 0 is the current one.
   function automatic logic [30:0] x1_step(input logic [30:0] s);
      return {s[3] ^ s[0], s[30:1]};
   endfunction

   function automatic logic [30:0] x2_step(input logic [30:0] s);
      return {s[3] ^ s[2] ^ s[1] ^ s[0], s[30:1]};
   endfunction

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p,
                                                 input logic [IDX_W-1:0] n);
      logic [IDX_W-1:0] q;
      q = p + IDX_W'(1);
      return (q == n) ? '0 : q;
   endfunction

   // Remainder goes out MSB first, so it lands in the buffer bit-reversed.
   always_comb begin
      crc_rev = '0;
      for (int i = 0; i < 16; i++) crc_rev[i] = crc[15-i];
   end

   assign c_init = Config ? {N_Rnti[14:0], N_Rapid, N_cell_ID}
                          : {N_Rnti, 5'b00000, N_cell_ID};

   assign rv_prod = (IDX_W+2)'(rv_number) * (IDX_W+2)'(n_len);
   assign k0      = IDX_W'(rv_prod >> 2);

   assign qm_len  = qm4 ? 17'd4 : 17'd2;
   assign e_short = available_coded_bits < ((modulation_order == 3'd4) ? 17'd4 : 17'd2);
   assign emit    = (state == ST_STREAM) && tick && (bits_left >= qm_len);
   assign fin     = (state == ST_STREAM) && tick && (bits_left <  qm_len);

   // Circular read positions for up to four bits of the current symbol.
   always_comb begin
      for (int k = 0; k < 5; k++) idx[k] = '0;
      bits_sc = '0;
      idx[0] = pos;
      for (int k = 1; k < 5; k++) idx[k] = wrap_inc(idx[k-1], n_len);
      for (int k = 0; k < 4; k++) bits_sc[k] = tb_buf[idx[k]] ^ x1[k] ^ x2[k];
      pos_nx = qm4 ? idx[4] : idx[2];
   end

   assign x1_nx = qm4 ? x1_step(x1_step(x1_step(x1_step(x1)))) : x1_step(x1_step(x1));
   assign x2_nx = qm4 ? x2_step(x2_step(x2_step(x2_step(x2)))) : x2_step(x2_step(x2));

   always_comb begin
      mag_i = AMP4;
      mag_q = AMP4;
      if (qm4) begin
         mag_i = bits_sc[2] ? AMP6 : AMP2;
         mag_q = bits_sc[3] ? AMP6 : AMP2;
      end
      sym_i = bits_sc[0] ? -mag_i : mag_i;
      sym_q = bits_sc[1] ? -mag_q : mag_q;
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (tick && enable) state_nx = ST_LOAD;
         ST_LOAD:   if (tick && !enable) state_nx = ST_CRC;
         ST_CRC:    state_nx = ST_WARM;
         ST_WARM:   if (warm_cnt == WARM_LAST) state_nx = e_short ? ST_IDLE : ST_STREAM;
         ST_STREAM: if (fin) state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tb_buf    <= '0;
         cap_cnt   <= '0;
         n_len     <= '0;
         pos       <= '0;
         crc       <= '0;
         x1        <= '0;
         x2        <= '0;
         warm_cnt  <= '0;
         bits_left <= '0;
         qm4       <= 1'b0;
         cfg_rsv   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tick && enable) begin
                  // Clearing the buffer here lets the CRC be OR-ed in above the data.
                  tb_buf  <= BUF_W'(Data_in);
                  cap_cnt <= IDX_W'(1);
                  crc     <= crc_upd(16'h0000, Data_in);
               end
            end
            ST_LOAD: begin
               if (tick && enable && (cap_cnt < MAX_CNT)) begin
                  tb_buf[cap_cnt] <= Data_in;
                  cap_cnt         <= cap_cnt + IDX_W'(1);
                  crc             <= crc_upd(crc, Data_in);
               end
            end
            ST_CRC: begin
               tb_buf   <= tb_buf | ({{MAX_TB{1'b0}}, crc_rev} << cap_cnt);
               n_len    <= cap_cnt + CRC_LEN;
               x1       <= 31'd1;
               x2       <= c_init;
               warm_cnt <= '0;
            end
            ST_WARM: begin
               x1       <= x1_step(x1);
               x2       <= x2_step(x2);
               warm_cnt <= warm_cnt + 11'd1;
               if (warm_cnt == WARM_LAST) begin
                  bits_left <= available_coded_bits;
                  qm4       <= (modulation_order == 3'd4);
                  pos       <= k0;
                  cfg_rsv   <= {base_graph, process_number, N_slot_frame, N_rb, En_hopping,
                                N_symbol, N_sc_start, Sym_Start_REM, Sym_End_REM};
               end
            end
            ST_STREAM: begin
               if (emit) begin
                  pos       <= pos_nx;
                  x1        <= x1_nx;
                  x2        <= x2_nx;
                  bits_left <= bits_left - qm_len;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- output registers ----------------
   logic out_rst;
   assign out_rst = reset | reset_fft;

   always_ff @(posedge clk or posedge out_rst) begin
      if (out_rst) begin
         Data_r     <= '0;
         Data_i     <= '0;
         Data_valid <= 1'b0;
      end else if (emit) begin
         Data_r     <= sym_i;
         Data_i     <= sym_q;
         Data_valid <= 1'b1;
      end else if (fin) begin
         Data_r     <= '0;
         Data_i     <= '0;
         Data_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pusch_top.sv
// Self-checking bench for pusch_top: table of transport blocks plus random ones, each compared
// against a spreadsheet-level model (long-division CRC, array Gold sequence, modulo indexing).
// Extra hand sequences cover reset_fft during streaming and a full reset mid-stream.
module tb_pusch_top;
   localparam int W = 26;
   localparam int U = 1 << (W - 5);

   logic clk = 1'b0;
   logic reset = 1'b1, reset_fft = 1'b0, reset_div = 1'b0;
   logic enable = 1'b0, Data_in = 1'b0;
   logic [1:0]  base_graph = 2'd1, rv_number = 2'd0, En_hopping = 2'd0;
   logic [3:0]  process_number = 4'd3, N_symbol = 4'd12, Sym_Start_REM = 4'd0, Sym_End_REM = 4'd13;
   logic [16:0] available_coded_bits = 17'd0;
   logic [2:0]  modulation_order = 3'd2;
   logic [5:0]  N_Rapid = 6'd0;
   logic [15:0] N_Rnti = 16'd0;
   logic [9:0]  N_cell_ID = 10'd0;
   logic        Config = 1'b0;
   logic [4:0]  N_slot_frame = 5'd7;
   logic [6:0]  N_rb = 7'd10;
   logic [10:0] N_sc_start = 11'd0;
   logic signed [W-1:0] Data_r, Data_i;
   logic        Data_valid;

   int checks = 0;
   int errors = 0;
   logic [3:0] m_cnt;
   int exp_r[$], exp_i[$], got_r[$], got_i[$];

   typedef struct {
      int         nbits;
      logic [127:0] pat;
      int         e;
      int         qm_in;
      int         rv;
      bit         cfg;
      int         rnti;
      int         cid;
      int         rapid;
      int         exp_syms;
   } vec_t;

   vec_t tbl[8];

   pusch_top #(.WIDTH_IFFT(W), .MAX_TB(64)) dut (
      .clk(clk), .reset(reset), .reset_fft(reset_fft), .reset_div(reset_div),
      .enable(enable), .Data_in(Data_in), .base_graph(base_graph), .rv_number(rv_number),
      .process_number(process_number), .available_coded_bits(available_coded_bits),
      .modulation_order(modulation_order), .N_Rapid(N_Rapid), .N_Rnti(N_Rnti),
      .N_cell_ID(N_cell_ID), .Config(Config), .N_slot_frame(N_slot_frame), .N_rb(N_rb),
      .En_hopping(En_hopping), .N_symbol(N_symbol), .N_sc_start(N_sc_start),
      .Sym_Start_REM(Sym_Start_REM), .Sym_End_REM(Sym_End_REM),
      .Data_r(Data_r), .Data_i(Data_i), .Data_valid(Data_valid)
   );

   always #5 clk = ~clk;

   // Tick reference: free-running /16 count, the tick edge is where it rolls 15 -> 0.
   always @(posedge clk or posedge reset or posedge reset_div) begin
      if (reset || reset_div) m_cnt <= 4'd0;
      else                    m_cnt <= m_cnt + 4'd1;
   end

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick_edge();
      int g = 0;
      do begin
         @(posedge clk);
         #1;
         g++;
      end while (m_cnt != 4'd0 && g < 40);
   endtask

   task automatic build_model(input vec_t v);
      bit tbuf[$];
      bit m[$];
      logic [16:0] poly;
      int a, n, k0, qm, nsym, len, j;
      longint ci;
      bit x1[], x2[];
      int bb[4];
      poly = 17'h11021;
      exp_r.delete();
      exp_i.delete();
      a = (v.nbits > 64) ? 64 : v.nbits;
      for (int i = 0; i < a; i++) tbuf.push_back(v.pat[i]);
      m = tbuf;
      for (int i = 0; i < 16; i++) m.push_back(1'b0);
      for (int i = 0; i < a; i++)
         if (m[i])
            for (int k = 0; k <= 16; k++) m[i+k] = m[i+k] ^ poly[16-k];
      for (int i = 0; i < 16; i++) tbuf.push_back(m[a+i]);
      n    = a + 16;
      k0   = (v.rv * n) / 4;
      qm   = (v.qm_in == 4) ? 4 : 2;
      nsym = v.e / qm;
      if (v.cfg) ci = (longint'(v.rnti) << 16) + (longint'(v.rapid) << 10) + longint'(v.cid);
      else       ci = (longint'(v.rnti) << 15) + longint'(v.cid);
      ci  = ci % (longint'(1) << 31);
      len = 1600 + v.e + 1;
      x1  = new[len + 31];
      x2  = new[len + 31];
      for (int i = 0; i < 31; i++) begin
         x1[i] = (i == 0);
         x2[i] = ci[i];
      end
      for (int i = 0; i < len; i++) begin
         x1[i+31] = x1[i+3] ^ x1[i];
         x2[i+31] = x2[i+3] ^ x2[i+2] ^ x2[i+1] ^ x2[i];
      end
      for (int s = 0; s < nsym; s++) begin
         for (int k = 0; k < 4; k++) bb[k] = 0;
         for (int k = 0; k < qm; k++) begin
            j = s * qm + k;
            bb[k] = tbuf[(k0 + j) % n] ^ x1[j+1600] ^ x2[j+1600];
         end
         if (qm == 2) begin
            exp_r.push_back((1 - 2*bb[0]) * 4 * U);
            exp_i.push_back((1 - 2*bb[1]) * 4 * U);
         end else begin
            exp_r.push_back((1 - 2*bb[0]) * (2 - (1 - 2*bb[2])) * 2 * U);
            exp_i.push_back((1 - 2*bb[1]) * (2 - (1 - 2*bb[3])) * 2 * U);
         end
      end
   endtask

   task automatic apply_cfg(input vec_t v);
      rv_number            = 2'(v.rv);
      available_coded_bits = 17'(v.e);
      modulation_order     = 3'(v.qm_in);
      N_Rnti               = 16'(v.rnti);
      N_cell_ID            = 10'(v.cid);
      N_Rapid              = 6'(v.rapid);
      Config               = v.cfg;
   endtask

   task automatic send_tb(input vec_t v);
      tick_edge();
      for (int i = 0; i < v.nbits; i++) begin
         enable  = 1'b1;
         Data_in = v.pat[i];
         tick_edge();
      end
      enable  = 1'b0;
      Data_in = 1'b0;
      tick_edge();
   endtask

   // Samples every clock: symbols are taken at tick edges, anything moving in between is counted.
   task automatic collect(input string tag, input int nexp, input int fft_after);
      int cyc = 0, budget, unstable = 0;
      bit seen = 0, done = 0;
      logic lv;
      logic signed [W-1:0] lr, li;
      got_r.delete();
      got_i.delete();
      budget = (120 + nexp) * 16;
      lv = Data_valid; lr = Data_r; li = Data_i;
      while (!done && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
         if (m_cnt == 4'd0) begin
            if (Data_valid) begin
               got_r.push_back(int'(Data_r));
               got_i.push_back(int'(Data_i));
               seen = 1;
               if (got_r.size() == fft_after) begin
                  #3 reset_fft = 1'b1;
                  #1;
                  chk({tag, " fft_rst valid"}, Data_valid, 0);
                  chk({tag, " fft_rst I"}, Data_r, 0);
                  chk({tag, " fft_rst Q"}, Data_i, 0);
                  reset_fft = 1'b0;
               end
            end else if (seen) begin
               done = 1;
            end
         end else if (Data_valid !== lv || Data_r !== lr || Data_i !== li) begin
            unstable++;
         end
         lv = Data_valid; lr = Data_r; li = Data_i;
      end
      if (nexp > 0) chk({tag, " finished"}, done, 1);
      chk({tag, " stable between ticks"}, unstable, 0);
   endtask

   task automatic run_case(input vec_t v, input int fft_after, input string tag);
      int mag;
      bit ok;
      apply_cfg(v);
      build_model(v);
      send_tb(v);
      collect(tag, v.exp_syms, fft_after);
      chk({tag, " symbol count"}, got_r.size(), v.exp_syms);
      for (int s = 0; s < got_r.size() && s < exp_r.size(); s++) begin
         chk($sformatf("%s sym%0d I", tag, s), got_r[s], exp_r[s]);
         chk($sformatf("%s sym%0d Q", tag, s), got_i[s], exp_i[s]);
         mag = (got_r[s] < 0) ? -got_r[s] : got_r[s];
         ok  = (v.qm_in == 4) ? (mag == 2*U || mag == 6*U) : (mag == 4*U);
         chk($sformatf("%s sym%0d magnitude", tag, s), ok, 1);
      end
   endtask

   initial begin
      vec_t v;
      int bad, cyc;

      //          nbits pattern                       E   qm rv cfg rnti   cid  rapid exp
      tbl[0] = '{1,  128'h1,                         144, 2, 0, 0, 50000, 900, 0,  72};
      tbl[1] = '{1,  128'h1,                         144, 2, 1, 0, 50000, 900, 0,  72};
      tbl[2] = '{5,  128'h16,                        8,   4, 0, 0, 50000, 900, 0,  2};
      tbl[3] = '{3,  128'h5,                         0,   2, 0, 0, 50000, 900, 0,  0};
      tbl[4] = '{4,  128'hB,                         10,  3, 2, 0, 1234,  17,  0,  5};
      tbl[5] = '{8,  128'hA7,                        50,  4, 2, 1, 50000, 900, 37, 12};
      tbl[6] = '{10, 128'h2C9,                       100, 2, 3, 1, 65535, 1023, 63, 50};
      tbl[7] = '{70, 128'h3F_0123_4567_89AB_CDEF,    40,  4, 1, 0, 777,   5,   0,  10};

      repeat (3) @(posedge clk);
      #1;
      chk("reset valid", Data_valid, 0);
      chk("reset I", Data_r, 0);
      chk("reset Q", Data_i, 0);
      reset = 1'b0;
      bad = 0;
      repeat (5) begin
         tick_edge();
         if (Data_valid) bad++;
      end
      chk("idle valid low", bad, 0);

      for (int t = 0; t < 8; t++) run_case(tbl[t], 0, $sformatf("vec%0d", t));

      // reset_fft mid-stream: outputs clear, symbol stream resumes in sequence.
      v = '{6, 128'h2D, 40, 2, 0, 0, 50000, 900, 0, 20};
      run_case(v, 5, "fft");

      // Full reset mid-stream.
      v = tbl[0];
      apply_cfg(v);
      send_tb(v);
      cyc = 0;
      while (!Data_valid && cyc < 130 * 16) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("rst stream started", Data_valid, 1);
      repeat (20) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("rst valid", Data_valid, 0);
      chk("rst I", Data_r, 0);
      chk("rst Q", Data_i, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      bad = 0;
      repeat (8) begin
         tick_edge();
         if (Data_valid) bad++;
      end
      chk("rst stays idle", bad, 0);
      run_case(tbl[2], 0, "after_rst");

      for (int r = 0; r < 4; r++) begin
         v.nbits    = $urandom_range(1, 20);
         v.pat      = {$urandom(), $urandom(), $urandom(), $urandom()};
         v.e        = $urandom_range(0, 60);
         v.qm_in    = $urandom_range(0, 7);
         v.rv       = $urandom_range(0, 3);
         v.cfg      = 1'($urandom_range(0, 1));
         v.rnti     = $urandom_range(0, 65535);
         v.cid      = $urandom_range(0, 1023);
         v.rapid    = $urandom_range(0, 63);
         v.exp_syms = v.e / ((v.qm_in == 4) ? 4 : 2);
         run_case(v, 0, $sformatf("rnd%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
